// File: rtl/contador_param_pkg.sv
// Shared MODO encodings for contador_param and anything that drives it.
package contador_param_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_STEP = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

endpackage

// File: rtl/contador_evt_cnt.sv
// Saturating event counter: clr wins over inc, holds at all-ones.
module contador_evt_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt != '1)) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_param.sv
// Parametrised multi-mode counter with terminal value, cascade carry and roll-over count.
// Define CONTADOR_SAT_EN to clamp at the bounds instead of wrapping.
module contador_param
  import contador_param_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CI,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] MAXV,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic [CNT_W-1:0] LOAD
);

  localparam int unsigned    W1       = WIDTH + 1;
  localparam logic [WIDTH:0] STEP_EXT = W1'(STEP);

  logic [WIDTH-1:0] q_d;
  logic             rco_d;
  logic             load_clr;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   maxv_ext;
`ifndef CONTADOR_SAT_EN
  logic [WIDTH:0]   wrap;
`endif

  always_comb begin
    q_d      = Q;
    rco_d    = 1'b0;
    load_clr = 1'b0;
    maxv_ext = {1'b0, MAXV};
    // One extra bit so Q+STEP cannot alias below MAXV.
    s        = {1'b0, Q} + STEP_EXT;
`ifndef CONTADOR_SAT_EN
    wrap     = s - (maxv_ext + W1'(1));
`endif
    if (ENABLE) begin
      if (MODO == MODO_LOAD) begin
        q_d      = D;
        load_clr = 1'b1;
      end else if (CI) begin
        case (MODO)
`ifndef CONTADOR_SAT_EN
          MODO_UP: begin
            if (Q >= MAXV) begin
              q_d   = '0;
              rco_d = 1'b1;
            end else begin
              q_d = Q + WIDTH'(1);
            end
          end
          MODO_DOWN: begin
            if (Q == '0) begin
              q_d   = MAXV;
              rco_d = 1'b1;
            end else begin
              q_d = Q - WIDTH'(1);
            end
          end
          MODO_STEP: begin
            if (s > maxv_ext) begin
              rco_d = 1'b1;
              // STEP larger than the whole range cannot land inside it.
              q_d   = (wrap > maxv_ext) ? '0 : wrap[WIDTH-1:0];
            end else begin
              q_d = s[WIDTH-1:0];
            end
          end
`else
          MODO_UP: begin
            if (Q >= MAXV) begin
              q_d = MAXV;
            end else begin
              q_d   = Q + WIDTH'(1);
              rco_d = (q_d == MAXV);
            end
          end
          MODO_DOWN: begin
            if (Q != '0) begin
              q_d   = Q - WIDTH'(1);
              rco_d = (q_d == '0);
            end
          end
          MODO_STEP: begin
            // Pulse only when entering the bound from below, never while parked there.
            if (Q >= MAXV) begin
              q_d = MAXV;
            end else if (s >= maxv_ext) begin
              q_d   = MAXV;
              rco_d = 1'b1;
            end else begin
              q_d = s[WIDTH-1:0];
            end
          end
`endif
          default: begin
            q_d = Q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else begin
      Q   <= q_d;
      RCO <= rco_d;
    end
  end

  contador_evt_cnt #(
    .CNT_W (CNT_W)
  ) u_evt_cnt (
    .clk (clk),
    .rst (RESET),
    .inc (rco_d),
    .clr (load_clr),
    .cnt (LOAD)
  );

endmodule
